// File: rtl/mips_memory_map.sv
module mips_memory_map #(
  parameter logic [11:0] RAM_REGION  = 12'h004,
  parameter logic [11:0] MMIO_REGION = 12'hFFF,
  parameter int unsigned RAM_AW      = 10,
  parameter              INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wr_data,
  input  logic        mem_wr_ena,
  output logic [31:0] mem_rd_data,
  output logic [15:0] leds,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        bus_error
);

  localparam int unsigned RAM_DEPTH = 1 << RAM_AW;

  localparam logic [7:0] OFF_LED   = 8'h00;
  localparam logic [7:0] OFF_CYCLE = 8'h04;
  localparam logic [7:0] OFF_TXD   = 8'h08;
  localparam logic [7:0] OFF_STAT  = 8'h0C;

  typedef enum logic [1:0] {
    REGION_RAM,
    REGION_MMIO,
    REGION_NONE
  } region_t;

  region_t           region;
  logic [RAM_AW-1:0] ram_idx;
  logic [7:0]        offset;

  assign ram_idx = mem_addr[RAM_AW+1:2];
  assign offset  = mem_addr[7:0];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_addr[19:RAM_AW+2], mem_addr[1:0]};

  always_comb begin
    if (mem_addr[31:20] == RAM_REGION) begin
      region = REGION_RAM;
    end else if (mem_addr[31:20] == MMIO_REGION) begin
      region = REGION_MMIO;
    end else begin
      region = REGION_NONE;
    end
  end

  logic ram_we;
  logic led_we;
  logic txd_we;
  logic stat_we;

  always_comb begin
    ram_we  = 1'b0;
    led_we  = 1'b0;
    txd_we  = 1'b0;
    stat_we = 1'b0;
    if (mem_wr_ena) begin
      case (region)
        REGION_RAM:  ram_we = 1'b1;
        REGION_MMIO: begin
          case (offset)
            OFF_LED:  led_we  = 1'b1;
            OFF_TXD:  txd_we  = 1'b1;
            OFF_STAT: stat_we = 1'b1;
            default:  ;
          endcase
        end
        default: ;
      endcase
    end
  end

  logic [31:0] ram [RAM_DEPTH];

  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[ram_idx] <= mem_wr_data;
    end
  end

  logic [31:0] cycle_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      leds        <= '0;
      cycle_count <= '0;
    end else begin
      cycle_count <= cycle_count + 32'd1;
      if (led_we) begin
        leds <= mem_wr_data[15:0];
      end
    end
  end

  logic [7:0] fifo_mem [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] fifo_count;
  logic       fifo_full;
  logic       overflow;
  logic       pop;
  logic       push_ok;

  assign fifo_full = (fifo_count == 3'd4);
  assign tx_valid  = (fifo_count != 3'd0);
  assign tx_data   = tx_valid ? fifo_mem[rd_ptr] : '0;
  assign pop       = tx_valid && tx_ready;
  // A same-cycle pop frees the slot, so a push at full still lands.
  assign push_ok   = txd_we && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= mem_wr_data[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      fifo_count <= fifo_count + 3'(push_ok) - 3'(pop);
      if (txd_we && !push_ok) begin
        overflow <= 1'b1;
      end else if (stat_we && mem_wr_data[4]) begin
        overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_error <= 1'b0;
    end else if (region == REGION_NONE) begin
      bus_error <= 1'b1;
    end
  end

  // Mux sees pre-edge state, giving read-first behaviour everywhere.
  logic [31:0] rd_next;

  always_comb begin
    rd_next = '0;
    case (region)
      REGION_RAM:  rd_next = ram[ram_idx];
      REGION_MMIO: begin
        case (offset)
          OFF_LED:   rd_next = {16'h0, leds};
          OFF_CYCLE: rd_next = cycle_count;
          OFF_STAT:  rd_next = {27'h0, overflow, fifo_full, fifo_count};
          default:   rd_next = '0;
        endcase
      end
      REGION_NONE: rd_next = 32'hDEAD_BEEF;
      default:     rd_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_rd_data <= '0;
    end else begin
      mem_rd_data <= rd_next;
    end
  end

endmodule
